// File: rtl/cpr_pkg.sv
// rtl/cpr_pkg.sv - shared state encoding and prefetch sizing for the cpr RAM reader
package cpr_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_FIN   = 2'd3
   } state_e;

   localparam int PREFETCH_DEPTH = 4;
   localparam int RD_LATENCY     = 2;

endpackage

// File: rtl/cpr_reader_fifo.sv
// rtl/cpr_reader_fifo.sv - small prefetch FIFO carrying {last, data} with occupancy output
module cpr_reader_fifo
   import cpr_pkg::*;
#(
   parameter int WIDTH = 33,
   parameter int DEPTH = PREFETCH_DEPTH
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       wdata_i,
   input  logic                   pop_i,
   output logic [WIDTH-1:0]       rdata_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]   count_q;
   logic             do_push, do_pop;

   assign do_pop  = pop_i && (count_q != '0);
   assign do_push = push_i && (count_q != (PTR_W+1)'(DEPTH));

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
      end
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

endmodule

// File: rtl/cpr_ram_reader.sv
// rtl/cpr_ram_reader.sv - streams a contiguous RAM address range out on a valid/ready port
// Reads are issued ahead of the consumer so output stalls never lose or repeat words.
module cpr_ram_reader
   import cpr_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 14
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   length,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_din,
   output logic                  ram_we,
   input  logic [DATA_WIDTH-1:0] ram_dout,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last
);
   localparam int               OCC_W   = $clog2(PREFETCH_DEPTH) + 1;
   localparam logic [OCC_W-1:0] DEPTH_L = OCC_W'(PREFETCH_DEPTH);
   localparam logic [ADDR_WIDTH:0] LEN_ONE = (ADDR_WIDTH+1)'(1);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH:0]   len_q, len_d;
   logic [ADDR_WIDTH:0]   issued_q, issued_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [RD_LATENCY-1:0] infl_vld_q, infl_last_q;
   logic                  issue, issue_last;
   logic [OCC_W-1:0]      fifo_count, infl_count;
   logic                  fifo_empty, head_last, pop, room;
   logic [DATA_WIDTH-1:0] head_data;

   always_comb begin
      infl_count = '0;
      for (int i = 0; i < RD_LATENCY; i++)
         infl_count = infl_count + OCC_W'(infl_vld_q[i]);
   end

   // Bound on words already committed (buffered or in flight) keeps the FIFO from overflowing
   // without ever looking at out_ready.
   assign room = (fifo_count + infl_count) < DEPTH_L;
   assign pop  = out_valid && out_ready;

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      issued_d   = issued_q;
      addr_d     = addr_q;
      issue      = 1'b0;
      issue_last = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               len_d    = length;
               issued_d = '0;
               if (length == '0) begin
                  state_d = ST_FIN;
               end else begin
                  issue      = 1'b1;
                  issue_last = (length == LEN_ONE);
                  addr_d     = base_addr;
                  issued_d   = LEN_ONE;
                  state_d    = ST_READ;
               end
            end
         end
         ST_READ: begin
            if (issued_q == len_q) begin
               state_d = ST_DRAIN;
            end else if (room) begin
               issue      = 1'b1;
               issue_last = (issued_q == len_q - 1'b1);
               addr_d     = addr_q + 1'b1;
               issued_d   = issued_q + 1'b1;
            end
         end
         ST_DRAIN: begin
            if (pop && head_last) state_d = ST_FIN;
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= ST_IDLE;
         len_q       <= '0;
         issued_q    <= '0;
         addr_q      <= '0;
         infl_vld_q  <= '0;
         infl_last_q <= '0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         issued_q    <= issued_d;
         addr_q      <= addr_d;
         infl_vld_q  <= {infl_vld_q[RD_LATENCY-2:0], issue};
         infl_last_q <= {infl_last_q[RD_LATENCY-2:0], issue_last};
      end
   end

   cpr_reader_fifo #(
      .WIDTH (DATA_WIDTH + 1),
      .DEPTH (PREFETCH_DEPTH)
   ) u_fifo (
      .clk_i   (CLK),
      .rst_n_i (RST_N),
      .push_i  (infl_vld_q[RD_LATENCY-1]),
      .wdata_i ({infl_last_q[RD_LATENCY-1], ram_dout}),
      .pop_i   (pop),
      .rdata_o ({head_last, head_data}),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign ram_addr  = addr_q;
   assign ram_din   = '0;
   assign ram_we    = 1'b0;
   assign out_valid = !fifo_empty;
   assign out_data  = head_data;
   // Stale slots may still hold an old last flag, so it is only meaningful with valid.
   assign out_last  = head_last && !fifo_empty;
   assign busy      = (state_q == ST_READ) || (state_q == ST_DRAIN);
   assign done      = (state_q == ST_FIN);

endmodule
